// File: rtl/data_break_arbiter.sv
// Round-robin data-break arbiter: picks one of four requesters, raises data_break
// to the CPU state machine, tracks the break and returns read data with an ack.
module data_break_arbiter #(
    parameter int unsigned TMO = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  dir,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [14:0] addr2,
    input  logic [14:0] addr3,
    input  logic [11:0] wdata0,
    input  logic [11:0] wdata1,
    input  logic [11:0] wdata2,
    input  logic [11:0] wdata3,
    input  logic        break_in_prog,
    input  logic [11:0] mem_data,
    input  logic        err_clr,
    output logic        data_break,
    output logic        to_disk,
    output logic [14:0] db_addr,
    output logic [11:0] db_wdata,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [11:0] db_rdata,
    output logic        tmo_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bip_q;
    logic               data_break_q, data_break_d;
    logic               to_disk_q, to_disk_d;
    logic [14:0]        db_addr_q, db_addr_d;
    logic [11:0]        db_wdata_q, db_wdata_d;
    logic [3:0]         grant_q, grant_d;
    logic [3:0]         ack_q, ack_d;
    logic [11:0]        db_rdata_q, db_rdata_d;
    logic               tmo_err_q, tmo_err_d;

    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand;
    logic [14:0]        win_addr;
    logic [11:0]        win_wdata;
    logic [1:0]         owner_idx;

    // Round-robin search starting one past the last owner
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    begin win_addr = addr0; win_wdata = wdata0; end
            2'd1:    begin win_addr = addr1; win_wdata = wdata1; end
            2'd2:    begin win_addr = addr2; win_wdata = wdata2; end
            default: begin win_addr = addr3; win_wdata = wdata3; end
        endcase
    end

    always_comb begin
        case (grant_q)
            4'b0010: owner_idx = 2'd1;
            4'b0100: owner_idx = 2'd2;
            4'b1000: owner_idx = 2'd3;
            default: owner_idx = 2'd0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        data_break_d = data_break_q;
        to_disk_d    = to_disk_q;
        db_addr_d    = db_addr_q;
        db_wdata_d   = db_wdata_q;
        grant_d      = grant_q;
        ack_d        = 4'd0;
        db_rdata_d   = db_rdata_q;
        tmo_err_d    = err_clr ? 1'b0 : tmo_err_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (win_found) begin
                    db_addr_d    = win_addr;
                    db_wdata_d   = win_wdata;
                    to_disk_d    = ~dir[win_idx];
                    grant_d      = 4'(1) << win_idx;
                    data_break_d = 1'b1;
                    cnt_d        = CNT_W'(TMO);
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (break_in_prog) begin
                    data_break_d = 1'b0;
                    state_d      = S_BUSY;
                end else if (cnt_q <= CNT_W'(1)) begin
                    // Counter expires this edge: abandon without ack or ptr update
                    cnt_d        = '0;
                    tmo_err_d    = 1'b1;
                    grant_d      = 4'd0;
                    data_break_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (bip_q && !break_in_prog) begin
                    db_rdata_d = mem_data;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                ack_d   = grant_q;
                ptr_d   = owner_idx;
                grant_d = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 2'd3;
            cnt_q        <= '0;
            bip_q        <= 1'b0;
            data_break_q <= 1'b0;
            to_disk_q    <= 1'b0;
            db_addr_q    <= 15'd0;
            db_wdata_q   <= 12'd0;
            grant_q      <= 4'd0;
            ack_q        <= 4'd0;
            db_rdata_q   <= 12'd0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            bip_q        <= break_in_prog;
            data_break_q <= data_break_d;
            to_disk_q    <= to_disk_d;
            db_addr_q    <= db_addr_d;
            db_wdata_q   <= db_wdata_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            db_rdata_q   <= db_rdata_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign data_break = data_break_q;
    assign to_disk    = to_disk_q;
    assign db_addr    = db_addr_q;
    assign db_wdata   = db_wdata_q;
    assign grant      = grant_q;
    assign ack        = ack_q;
    assign db_rdata   = db_rdata_q;
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_data_break_arbiter.sv
// Scoreboard bench for data_break_arbiter: a CPU model drives break_in_prog while
// a monitor matches grant, ack and timeout events against queued expectations.
module tb_data_break_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [14:0] addr_a [4];
    logic [11:0] wdata_a [4];
    logic        break_in_prog;
    logic [11:0] mem_data;
    logic        err_clr;
    logic        data_break, to_disk, tmo_err;
    logic [14:0] db_addr;
    logic [11:0] db_wdata, db_rdata;
    logic [3:0]  grant, ack;

    typedef struct {
        logic [3:0]  grant;
        logic        to_disk;
        logic [14:0] addr;
        logic [11:0] wdata;
    } gexp_t;

    typedef struct {
        logic        is_tmo;
        logic [3:0]  ack;
        logic [11:0] rdata;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    int n_checks = 0;
    int n_fail   = 0;

    data_break_arbiter #(.TMO(4)) dut (
        .clk(clk), .reset(reset), .req(req), .dir(dir),
        .addr0(addr_a[0]), .addr1(addr_a[1]), .addr2(addr_a[2]), .addr3(addr_a[3]),
        .wdata0(wdata_a[0]), .wdata1(wdata_a[1]), .wdata2(wdata_a[2]), .wdata3(wdata_a[3]),
        .break_in_prog(break_in_prog), .mem_data(mem_data), .err_clr(err_clr),
        .data_break(data_break), .to_disk(to_disk), .db_addr(db_addr),
        .db_wdata(db_wdata), .grant(grant), .ack(ack), .db_rdata(db_rdata),
        .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    function automatic int idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    // Monitor: compares DUT events against the scoreboard queues
    initial begin
        logic db_prev, tmo_prev;
        logic lat_td;
        logic [14:0] lat_addr;
        logic [11:0] lat_wdata;
        gexp_t ge;
        dexp_t de;
        db_prev = 1'b0; tmo_prev = 1'b0;
        lat_td = 1'b0; lat_addr = '0; lat_wdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (data_break && !db_prev) begin
                    if (gq.size() == 0) unexpected("unexpected_grant", 32'(grant));
                    else begin
                        ge = gq.pop_front();
                        check("grant", 32'(grant), 32'(ge.grant));
                        check("to_disk", 32'(to_disk), 32'(ge.to_disk));
                        check("db_addr", 32'(db_addr), 32'(ge.addr));
                        check("db_wdata", 32'(db_wdata), 32'(ge.wdata));
                    end
                    lat_td = to_disk; lat_addr = db_addr; lat_wdata = db_wdata;
                end
                if (grant != 4'd0 && !data_break) begin
                    check("busy_to_disk_stable", 32'(to_disk), 32'(lat_td));
                    check("busy_addr_stable", 32'(db_addr), 32'(lat_addr));
                    check("busy_wdata_stable", 32'(db_wdata), 32'(lat_wdata));
                end
                if (ack != 4'd0) begin
                    check("ack_onehot", 32'($onehot(ack)), 32'd1);
                    check("ack_grant_excl", 32'(grant == 4'd0 || grant == ack), 32'd1);
                    if (dq.size() == 0) unexpected("unexpected_ack", 32'(ack));
                    else begin
                        de = dq.pop_front();
                        check("ack_not_tmo", 32'(de.is_tmo), 32'd0);
                        check("ack", 32'(ack), 32'(de.ack));
                        check("db_rdata", 32'(db_rdata), 32'(de.rdata));
                    end
                end
                if (tmo_err && !tmo_prev) begin
                    if (dq.size() == 0) unexpected("unexpected_tmo", 32'(tmo_err));
                    else begin
                        de = dq.pop_front();
                        check("tmo_event", 32'(de.is_tmo), 32'd1);
                    end
                end
            end
            db_prev  = data_break;
            tmo_prev = tmo_err;
        end
    end

    task automatic wait_db(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_break) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_data_break: got timeout expected data_break=1");
        end
    endtask

    // CPU model for one break; hi = cycles break_in_prog stays high
    task automatic run_break(input logic [3:0] g, input int hi, input logic [11:0] md, input bit drop);
        bit ok;
        int ix;
        ix = idx_of(g);
        gq.push_back('{g, ~dir[ix], addr_a[ix], wdata_a[ix]});
        dq.push_back('{1'b0, g, md});
        wait_db(ok);
        if (ok) begin
            if (drop) req = 4'd0;
            break_in_prog = 1'b1;
            mem_data = ~md;
            @(negedge clk);
            check("db_low_after_bip", 32'(data_break), 32'd0);
            repeat (hi - 1) @(negedge clk);
            break_in_prog = 1'b0;
            mem_data = md;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        bit ok;
        int highs;
        reset = 1'b1; req = 4'd0; dir = 4'b0100;
        break_in_prog = 1'b0; mem_data = 12'd0; err_clr = 1'b0;
        addr_a[0] = 15'o12345; addr_a[1] = 15'o00101; addr_a[2] = 15'o22222; addr_a[3] = 15'o77770;
        wdata_a[0] = 12'o1111; wdata_a[1] = 12'o2222; wdata_a[2] = 12'o4321; wdata_a[3] = 12'o7654;
        repeat (3) @(negedge clk);
        check("rst_data_break", 32'(data_break), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_to_disk", 32'(to_disk), 32'd0);
        check("rst_db_addr", 32'(db_addr), 32'd0);
        check("rst_db_wdata", 32'(db_wdata), 32'd0);
        check("rst_db_rdata", 32'(db_rdata), 32'd0);
        check("rst_tmo_err", 32'(tmo_err), 32'd0);
        reset = 1'b0;

        // Single read from the RK8E
        req = 4'b0001;
        run_break(4'b0001, 3, 12'o7070, 1'b1);
        mem_data = 12'o0123;
        repeat (3) @(negedge clk);
        check("rdata_held", 32'(db_rdata), 32'o7070);

        // Contention after reset: 0,1,2,3 then 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        run_break(4'b0001, 2, 12'o0001, 1'b0);
        run_break(4'b0010, 3, 12'o0002, 1'b0);
        run_break(4'b0100, 2, 12'o0004, 1'b0);
        run_break(4'b1000, 4, 12'o0010, 1'b0);
        run_break(4'b0001, 2, 12'o5555, 1'b1);

        // Write from requester 2
        req = 4'b0100;
        run_break(4'b0100, 4, 12'o0055, 1'b1);

        // Request withdrawn before ARB completes: no grant
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        check("arb_drop_grant", 32'(grant), 32'd0);
        check("arb_drop_db", 32'(data_break), 32'd0);

        // break_in_prog while idle is ignored
        break_in_prog = 1'b1;
        mem_data = 12'o3333;
        repeat (2) @(negedge clk);
        break_in_prog = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_bip_db", 32'(data_break), 32'd0);
        check("idle_bip_grant", 32'(grant), 32'd0);
        check("idle_bip_rdata", 32'(db_rdata), 32'o0055);

        // Timeout: TMO=4, no break_in_prog
        gq.push_back('{4'b0010, ~dir[1], addr_a[1], wdata_a[1]});
        dq.push_back('{1'b1, 4'd0, 12'd0});
        req = 4'b0010;
        wait_db(ok);
        req = 4'd0;
        highs = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_break) highs++;
            else break;
        end
        check("tmo_db_cycles", 32'(highs), 32'd4);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 32'(tmo_err), 32'd1);
        check("tmo_grant", 32'(grant), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_err_cleared", 32'(tmo_err), 32'd0);

        // Reset during BUSY: no ack, pointer restarts
        gq.push_back('{4'b0100, ~dir[2], addr_a[2], wdata_a[2]});
        req = 4'b0100;
        wait_db(ok);
        req = 4'd0;
        break_in_prog = 1'b1;
        @(negedge clk);
        check("mid_busy_db", 32'(data_break), 32'd0);
        check("mid_busy_grant", 32'(grant), 32'b0100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        break_in_prog = 1'b0;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_db", 32'(data_break), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_rdata", 32'(db_rdata), 32'd0);
        repeat (4) @(negedge clk);
        req = 4'b1111;
        run_break(4'b0001, 2, 12'o6161, 1'b1);

        repeat (5) @(negedge clk);
        check("gq_drained", 32'(gq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
